// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches the last PAT_W accepted bits against a loadable
// pattern, with overlapping/non-overlapping modes and a saturating match counter.
module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, nh;
  logic [FW-1:0]    fill_q, fill_d, nf;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d, sat_q, sat_d, match;

  assign nh    = {hist_q[PAT_W-2:0], in};
  assign nf    = (fill_q == FULL) ? FULL : fill_q + FW'(1);
  assign match = in_valid && (nh == pat_q) && (nf == FULL);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    out_d  = 1'b0;
    if (pat_load) begin
      // restart: the same-cycle serial bit is dropped
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end else if (in_valid) begin
      hist_d = nh;
      out_d  = match;
      fill_d = (match && !overlap) ? '0 : nf;
      if (match && (cnt_q != CMAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CMAX) sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      out_q  <= out_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: a vector table plus hand-written corner sequences,
// expected outputs queued at drive time and compared after each edge.
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic rst, in, in_valid, pat_load, overlap;
  logic [3:0] pattern;
  logic       out1, sat1, out2, sat2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .out(out1), .match_count(cnt1), .count_sat(sat1));

  seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .out(out2), .match_count(cnt2), .count_sat(sat2));

  typedef struct {
    logic       r, ld;
    logic [3:0] pat;
    logic       v, b, ov;
    logic       eo;
    logic [7:0] ec;
    logic       es;
    logic       chk2;
    logic [1:0] ec2;
    logic       es2;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0, failures = 0;

  function automatic vec_t mk(logic r, logic ld, logic [3:0] pat, logic v, logic b, logic ov,
                              logic eo, logic [7:0] ec, logic es,
                              logic chk2 = 1'b0, logic [1:0] ec2 = 2'd0, logic es2 = 1'b0);
    vec_t t;
    t.r = r; t.ld = ld; t.pat = pat; t.v = v; t.b = b; t.ov = ov;
    t.eo = eo; t.ec = ec; t.es = es; t.chk2 = chk2; t.ec2 = ec2; t.es2 = es2;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(vec_t t, string tag);
    vec_t e;
    @(negedge clk);
    rst = t.r; pat_load = t.ld; pattern = t.pat; in_valid = t.v; in = t.b; overlap = t.ov;
    sb.push_back(t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".out"}, 32'(out1), 32'(e.eo));
      chk({tag, ".cnt"}, 32'(cnt1), 32'(e.ec));
      chk({tag, ".sat"}, 32'(sat1), 32'(e.es));
      if (e.chk2) begin
        chk({tag, ".out2"}, 32'(out2), 32'(e.eo));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(e.ec2));
        chk({tag, ".sat2"}, 32'(sat2), 32'(e.es2));
      end
    end
  endtask

  // serial data bit with explicit expectations
  task automatic bit_in(logic b, logic ov, logic eo, logic [7:0] ec, string tag);
    step(mk(0, 0, 4'h0, 1, b, ov, eo, ec, 0), tag);
  endtask

  initial begin
    rst = 1; pat_load = 0; pattern = 0; in_valid = 0; in = 0; overlap = 0;

    // reset, then overlap / non-overlap / saturation in the table
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'hB, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 4'hB, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'hF, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 2, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 3, 0, 1, 3, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 4, 0, 1, 3, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 1, 5, 0, 1, 3, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // gap with in_valid=0 keeps the partial history
    step(mk(0, 1, 4'hB, 0, 0, 1, 0, 0, 0), "gap.load");
    bit_in(1, 1, 0, 0, "gap.b1");
    bit_in(0, 1, 0, 0, "gap.b2");
    for (int i = 0; i < 5; i++) step(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 0), $sformatf("gap.idle%0d", i));
    bit_in(1, 1, 0, 0, "gap.b3");
    bit_in(1, 1, 1, 1, "gap.b4");

    // load discards the same-cycle bit and the stale partial stream
    bit_in(1, 1, 0, 1, "ld.s1");
    bit_in(0, 1, 0, 1, "ld.s2");
    bit_in(1, 1, 0, 1, "ld.s3");
    step(mk(0, 1, 4'h6, 1, 1, 1, 0, 0, 0), "ld.load");
    bit_in(0, 1, 0, 0, "ld.b1");
    bit_in(1, 1, 0, 0, "ld.b2");
    bit_in(1, 1, 0, 0, "ld.b3");
    bit_in(0, 1, 1, 1, "ld.b4");

    // mid-stream reset clears everything; pattern reverts to zero
    bit_in(1, 1, 0, 1, "rs.s1");
    bit_in(0, 1, 0, 1, "rs.s2");
    bit_in(1, 1, 0, 1, "rs.s3");
    step(mk(1, 0, 4'h0, 1, 1, 1, 0, 0, 0, 1, 0, 0), "rs.rst");
    bit_in(1, 1, 0, 0, "rs.b1");
    bit_in(0, 1, 0, 0, "rs.b2");
    bit_in(1, 1, 0, 0, "rs.b3");
    bit_in(1, 1, 0, 0, "rs.b4");

    // all-zero pattern after reset matches PAT_W zeros with no load
    step(mk(1, 0, 4'h0, 0, 0, 1, 0, 0, 0), "z.rst");
    bit_in(0, 1, 0, 0, "z.b1");
    bit_in(0, 1, 0, 0, "z.b2");
    bit_in(0, 1, 0, 0, "z.b3");
    bit_in(0, 1, 1, 1, "z.b4");
    bit_in(0, 1, 1, 2, "z.b5");
    bit_in(0, 0, 1, 3, "z.b6");
    bit_in(0, 0, 0, 3, "z.b7");

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector, the successor to the fixed-sequence detector. It watches a 1-bit serial stream qualified by a valid strobe and pulses `out` when the last `PAT_W` accepted bits equal a runtime-loadable pattern. Overlapping and non-overlapping detection are both supported, and matches are counted in a saturating counter. It sits on the serial input path and feeds event/statistics logic downstream.

## Interface
- `PAT_W`, 4: pattern length in bits; legal range 2..16.
- `CNT_W`, 8: width of the match counter; legal range 1..32.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is accepted on a rising edge only when this is 1.
- `pattern`  in  PAT_W  pattern value, sampled only when `pat_load`=1.
- `pat_load`  in  1  load `pattern` and restart detection.
- `overlap`  in  1  1 = overlapping mode; 0 = non-overlapping mode; sampled every cycle.
- `out`  out  1  one-cycle match pulse, registered.
- `match_count`  out  CNT_W  number of matches, saturating.
- `count_sat`  out  1  sticky flag; set when `match_count` reaches its maximum.

## Operation
- Internal state:
  - `pat_reg[PAT_W-1:0]`: loaded pattern.
  - `hist[PAT_W-1:0]`: shift history. MSB is the oldest bit; an accepted bit shifts in at the LSB.
  - `fill`: count of accepted bits since the last restart, saturating at PAT_W.
- Bit order: `pattern[PAT_W-1]` is compared against the first bit received of the PAT_W-bit window.
- Priority on each rising edge: `rst` > `pat_load` > `in_valid`.
- `rst`=1: `pat_reg`=0, `hist`=0, `fill`=0, `out`=0, `match_count`=0, `count_sat`=0.
- `pat_load`=1 (no `rst`):
  - `pat_reg`←`pattern`; `hist`←0; `fill`←0.
  - `match_count`←0; `count_sat`←0; `out`←0.
  - Any `in_valid` bit in the same cycle is discarded.
- `in_valid`=1 (no `rst`, no `pat_load`):
  - Next history: `nh` = {`hist[PAT_W-2:0]`, `in`}.
  - Next fill: `nf` = min(`fill`+1, PAT_W).
  - Match = (`nh` == `pat_reg`) && (`nf` == PAT_W).
  - `hist`←`nh`; `out`←match.
  - On match with `overlap`=1: `fill`←`nf`.
  - On match with `overlap`=0: `fill`←0, so the next match needs PAT_W fresh bits. `hist` still takes `nh`.
  - With no match: `fill`←`nf`.
- `in_valid`=0 (no `rst`, no `pat_load`): `hist` and `fill` hold; `out`←0.
- Counter:
  - On match, if `match_count` < 2^CNT_W−1, `match_count` increments.
  - When the increment reaches 2^CNT_W−1, `count_sat`←1 in the same edge.
  - Further matches leave the counter at maximum and still pulse `out`.
- `overlap` is not a state machine. It only selects the `fill` update on a match cycle, so a toggle mid-stream takes effect on the next match.
- Two-state control view: FILLING (`fill` < PAT_W) and ARMED (`fill` == PAT_W).
  - FILLING → ARMED on the PAT_W-th accepted bit.
  - ARMED → FILLING on `rst`, `pat_load`, or a non-overlapping match.

## Timing
- `out` rises immediately after the rising edge that accepts the completing bit. It is high for exactly one clock, and there is no additional latency.
- `match_count` and `count_sat` update on that same edge.
- Back-to-back `out` pulses are possible only in overlapping mode, with consecutive valid bits and a self-overlapping pattern (e.g. all-ones).
- A first match needs at least PAT_W accepted bits after reset or load. Gaps with `in_valid`=0 do not reset the history.
- A reset asserted mid-stream clears all state on that edge. A partially received pattern never completes a match afterwards.
- After reset, `pat_reg`=0. A stream of PAT_W zeros therefore matches without any load.

## Test plan
- PAT_W=4, load 4'b1011, `overlap`=1, send 1,0,1,1,0,1,1 with `in_valid`=1 → `out` pulses after bits 4 and 7; `match_count`=2.
- Same pattern and stream, `overlap`=0 → `out` pulses after bit 4 only; `match_count`=1.
- Load 4'b1011, send 1,0 then `in_valid`=0 for 5 cycles, then 1,1 → `out` pulses after the final bit; no pulse during the gap.
- Send 1,0,1; assert `pat_load` with pattern 4'b0110 and `in_valid`=1, `in`=1 in the same cycle; then send 0,1,1,0 → exactly one pulse, after the last 0. The bit in the load cycle is discarded, and nothing matches on the stale 101.
- CNT_W=2, pattern 4'b1111, `overlap`=1, send 8 ones → 5 `out` pulses on bits 4..8; `match_count` ends at 3; `count_sat` rises on the 3rd match and stays 1.
- Send 1,0,1, assert `rst` for one cycle, then send 1 → no pulse; all outputs 0 after the reset edge. Then send 0,1,1 → no pulse, because `pat_reg`=0 after reset.
